// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 host transmitter and keyboard receiver.
//   - tx_state_e         : host-to-device transmit FSM encoding
//   - CMD_*              : common host command bytes
//   - *_DEF              : default timing parameters shared with the receiver
//   - odd_parity()       : PS/2 frame parity bit for a data byte
package ps2_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StRts,
        StSend,
        StAck,
        StWaitIdle
    } tx_state_e;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    localparam int unsigned INHIBIT_CYCLES_DEF = 10000;   // 100 us at 100 MHz
    localparam int unsigned FILTER_LEN_DEF     = 8;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 2000000; // 20 ms at 100 MHz

    // Parity bit that makes the 9-bit {parity, data} word have an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] i_data);
        return ~^i_data;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command/status and pad bundle between a controller and ps2_host_tx.
//   ps2c_in, ps2d_in  : raw pad levels
//   wr_en, din        : one-cycle send request and command byte
//   ps2c_oe, ps2d_oe  : open-drain pull-low enables
//   tx_busy           : transfer in flight (also gates the receiver)
//   tx_done, tx_err   : one-cycle completion pulses (ack / nack or timeout)
// Modports: master = controller and pads, slave = transmitter.
interface ps2_host_tx_if;

    logic       ps2c_in;
    logic       ps2d_in;
    logic       wr_en;
    logic [7:0] din;
    logic       ps2c_oe;
    logic       ps2d_oe;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;

    modport master (
        output ps2c_in, ps2d_in, wr_en, din,
        input  ps2c_oe, ps2d_oe, tx_busy, tx_done, tx_err
    );

    modport slave (
        input  ps2c_in, ps2d_in, wr_en, din,
        output ps2c_oe, ps2d_oe, tx_busy, tx_done, tx_err
    );

endinterface

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-FF synchroniser plus debounce for one PS/2 line.
//   i_clk, i_reset : system clock, synchronous active-high reset
//   i_pad          : raw pad level
//   o_level        : filtered level; changes after FILTER_LEN equal synchronised samples
//   o_fall         : one-cycle strobe when o_level goes 1 -> 0
// Synchroniser and filtered level reset to 1 (idle bus).
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_pad,
    output logic o_level,
    output logic o_fall
);

    localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic [1:0]    r_sync;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          r_fall;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync  <= 2'b11;
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_fall  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_pad};
            r_fall <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                // FILTER_LEN consecutive differing samples: accept the new level
                r_level <= r_sync[1];
                r_cnt   <= '0;
                r_fall  <= r_level;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
//   i_clk, i_reset : system clock, synchronous active-high reset
//   io_bus         : ps2_host_tx_if.slave (pads, wr_en/din request, oe drives, status pulses)
// Sequence: inhibit (ps2c low) -> request-to-send (ps2d low) -> shift data, parity, stop on
// each device clock fall -> sample ack on the next fall -> wait for idle lines -> pulse
// tx_done (ack) or tx_err (nack).
// Optional macro PS2_TX_TIMEOUT_EN: watchdog of TIMEOUT_CYCLES from SEND entry through
// WAIT_IDLE; expiry releases both lines and pulses tx_err.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
    parameter int unsigned FILTER_LEN     = FILTER_LEN_DEF
`ifdef PS2_TX_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
    input  logic          i_clk,
    input  logic          i_reset,
    ps2_host_tx_if.slave  io_bus
);

    localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);

    tx_state_e     r_state;
    tx_state_e     w_state_next;
    logic [9:0]    r_frame;    // {stop, parity, data}, sent LSB first
    logic [3:0]    r_idx;
    logic [IW-1:0] r_inh_cnt;
    logic          r_d_oe;
    logic          r_ack;
    logic          r_tx_done;
    logic          r_tx_err;
    logic [1:0]    r_dsync;

    logic          w_c_level;
    logic          w_c_fall;
    logic          w_accept;
    logic          w_shift;
    logic          w_sample;
    logic          w_finish;
    logic          w_tmo;
    logic          w_in_xfer;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_c_filter (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_pad   (io_bus.ps2c_in),
        .o_level (w_c_level),
        .o_fall  (w_c_fall)
    );

    assign w_in_xfer = (r_state == StSend) || (r_state == StAck) || (r_state == StWaitIdle);

`ifdef PS2_TX_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_tmo;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tmo <= '0;
        end else if (r_state == StRts) begin
            r_tmo <= '0;
        end else if (w_in_xfer) begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    assign w_tmo = w_in_xfer && (r_tmo == TMO_LAST);
`else
    assign w_tmo = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_shift      = 1'b0;
        w_sample     = 1'b0;
        w_finish     = 1'b0;
        unique case (r_state)
            StIdle: begin
                // The cycle carrying a done/err pulse still refuses new work
                if (io_bus.wr_en && !r_tx_done && !r_tx_err) begin
                    w_accept     = 1'b1;
                    w_state_next = StInhibit;
                end
            end
            StInhibit: begin
                if (r_inh_cnt == INH_LAST) begin
                    w_state_next = StRts;
                end
            end
            StRts: begin
                w_state_next = StSend;
            end
            StSend: begin
                if (w_c_fall) begin
                    w_shift = 1'b1;
                    if (r_idx == 4'd9) begin
                        w_state_next = StAck;
                    end
                end
            end
            StAck: begin
                if (w_c_fall) begin
                    w_sample     = 1'b1;
                    w_state_next = StWaitIdle;
                end
            end
            StWaitIdle: begin
                if (w_c_level && r_dsync[1]) begin
                    w_finish     = 1'b1;
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
        // Watchdog overrides whatever the transfer was doing
        if (w_tmo) begin
            w_shift      = 1'b0;
            w_sample     = 1'b0;
            w_finish     = 1'b0;
            w_state_next = StIdle;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= StIdle;
            r_frame   <= '0;
            r_idx     <= '0;
            r_inh_cnt <= '0;
            r_d_oe    <= 1'b0;
            r_ack     <= 1'b0;
            r_tx_done <= 1'b0;
            r_tx_err  <= 1'b0;
            r_dsync   <= 2'b11;
        end else begin
            r_state   <= w_state_next;
            r_dsync   <= {r_dsync[0], io_bus.ps2d_in};
            r_tx_done <= w_finish && r_ack;
            r_tx_err  <= (w_finish && !r_ack) || w_tmo;
            if (w_accept) begin
                r_frame   <= {1'b1, odd_parity(io_bus.din), io_bus.din};
                r_idx     <= '0;
                r_inh_cnt <= '0;
            end else if (r_state == StInhibit) begin
                r_inh_cnt <= r_inh_cnt + 1'b1;
            end
            // Start bit is held from RTS until the first device clock fall
            if (r_state == StInhibit && w_state_next == StRts) begin
                r_d_oe <= 1'b1;
            end
            if (w_shift) begin
                r_d_oe <= ~r_frame[r_idx];
                r_idx  <= r_idx + 1'b1;
            end
            if (w_sample) begin
                r_ack <= ~r_dsync[1];
            end
        end
    end

    assign io_bus.ps2c_oe = (r_state == StInhibit) || (r_state == StRts);
    assign io_bus.ps2d_oe = ((r_state == StRts) || (r_state == StSend)) && r_d_oe;
    assign io_bus.tx_busy = (r_state != StIdle);
    assign io_bus.tx_done = r_tx_done;
    assign io_bus.tx_err  = r_tx_err;

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) from the controller to the keyboard over the same ps2c/ps2d lines the keyboard receiver listens on. It sits beside the keyboard receiver under the keyboard top. It drives the open-drain lines through output-enable pins and holds the receiver off while a transfer is in flight. It performs the full inhibit / request-to-send / clocked-shift / acknowledge sequence and reports done or error.

## Interface
- INHIBIT_CYCLES, 10000: clk cycles the host holds ps2c low before request-to-send (100 µs at 100 MHz).
- FILTER_LEN, 8: consecutive equal samples needed before a ps2c level change is accepted.
- TIMEOUT_CYCLES, 2000000: watchdog limit, from clock release to end of transfer (20 ms); used only with PS2_TX_TIMEOUT_EN.
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- ps2c_in  in  1  raw level of the ps2c pad.
- ps2d_in  in  1  raw level of the ps2d pad.
- wr_en  in  1  one-cycle request to send din; honoured only when tx_busy=0.
- din  in  8  command byte.
- ps2c_oe  out  1  1 = pull ps2c low; 0 = release.
- ps2d_oe  out  1  1 = pull ps2d low; 0 = release.
- tx_busy  out  1  transfer in progress; also gates the receiver (receiver ignores frames while high).
- tx_done  out  1  one-cycle pulse: device acknowledged.
- tx_err  out  1  one-cycle pulse: NACK or timeout.

## Operation
- ps2c_in and ps2d_in each pass through a 2-FF synchroniser. ps2c is then filtered: the filtered level changes only after FILTER_LEN equal synchronised samples. fall = filtered ps2c 1→0.
- The frame register latches {stop=1, parity=~^din, din} on acceptance. Bits are sent LSB first. Parity is odd.
- States:
  - IDLE: both oe=0. wr_en → INHIBIT and latch the frame.
  - INHIBIT: ps2c_oe=1 for INHIBIT_CYCLES cycles → RTS.
  - RTS: ps2c_oe=1, ps2d_oe=1 (start bit) for 1 cycle → SEND.
  - SEND: ps2c_oe=0. On each fall, present the next frame bit: ps2d_oe = ~bit. Bits go din[0..7], then parity, then stop (ps2d released). After the fall that presents stop → ACK.
  - ACK: both oe=0. On the next fall, sample synchronised ps2d: 0 = ack, 1 = nack. Record the result → WAIT_IDLE.
  - WAIT_IDLE: wait until filtered ps2c=1 and synchronised ps2d=1. Then pulse tx_done (ack) or tx_err (nack) → IDLE.
- wr_en while tx_busy=1 is ignored. There is no queue; a wr_en coincident with tx_done is also ignored.
- Device-initiated traffic during INHIBIT is overridden by the host, as the PS/2 protocol requires.
- Reset mid-transfer: on the next edge both lines are released, the state returns to IDLE, and no done/err pulse is produced.

## Timing
- Reset values: ps2c_oe=0, ps2d_oe=0, tx_busy=0, tx_done=0, tx_err=0. Filter and synchronisers reset to 1.
- wr_en sampled at edge N → tx_busy=1 and ps2c_oe=1 from N+1.
- ps2c_oe stays high for exactly INHIBIT_CYCLES+1 cycles (INHIBIT plus RTS). ps2d_oe rises in the last of those cycles.
- Each data bit changes ps2d_oe one cycle after the filtered fall is detected. Fall detection lags the pad by 2+FILTER_LEN cycles.
- tx_busy drops in the same cycle tx_done/tx_err pulses. A new wr_en is accepted the following cycle.

## Configuration
- PS2_TX_TIMEOUT_EN defined: a counter starts on entry to SEND and runs through WAIT_IDLE. Reaching TIMEOUT_CYCLES forces both oe=0, pulses tx_err, and returns to IDLE.
- PS2_TX_TIMEOUT_EN undefined: no counter. A silent device leaves the block in SEND, ACK or WAIT_IDLE until reset.

## Structure
- Shared package ps2_pkg:
  - state encoding (IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE);
  - command constants CMD_SET_LEDS=8'hED, CMD_ENABLE=8'hF4, CMD_RESET=8'hFF;
  - default INHIBIT_CYCLES/FILTER_LEN values shared with the receiver.
- One sub-module, ps2_line_filter (synchroniser + FILTER_LEN debounce + fall strobe). It is instanced for ps2c here and reusable by the receiver.

## Test plan
- din=0xED, device model clocks 11 falls at 12.5 kHz and drives ack → ps2d_oe sequence per fall ~{1,0,1,1,0,1,1,1}, parity 1 (oe 0), stop released; tx_done=1 once, tx_err never.
- din=0xF4 → data bits 0,0,1,0,1,1,1,1, parity 0 (ps2d_oe=1 during the parity bit); ps2c_oe high exactly INHIBIT_CYCLES+1 cycles after wr_en.
- Device leaves ps2d high at the 11th fall → tx_err pulse, tx_done=0, busy drops after lines idle.
- wr_en pulsed again mid-transfer with din=0xFF → ignored; the frame on the wire remains the first byte.
- Reset asserted after 4th fall → next cycle both oe=0, tx_busy=0, no pulses; a fresh 0xF4 transfer then completes.
- PS2_TX_TIMEOUT_EN defined, device never clocks → tx_err exactly TIMEOUT_CYCLES after SEND entry, both lines released.
